// File: rtl/conv_pkg.sv
// conv_pkg
// Shared definitions for conv_mac_engine and its mac_lane sub-modules:
//   - state_t : engine FSM states
//   - DEF_*   : default width / depth constants
//   - relu_zero(): decides whether a result is forced to zero by ReLU
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int unsigned DEF_DATA_W      = 8;
    localparam int unsigned DEF_ACC_W       = 24;
    localparam int unsigned DEF_NUM_FILTERS = 4;
    localparam int unsigned DEF_WIN         = 16;
    localparam int unsigned NUM_WIN_W       = 16;

    // A result is zeroed only when ReLU is enabled and the accumulator is negative.
    function automatic logic relu_zero(input logic relu_en, input logic sign_bit);
        return relu_en && sign_bit;
    endfunction

endpackage

// File: rtl/mac_lane.sv
// mac_lane
// One filter of the convolution engine: a WIN-entry coefficient register file,
// a tap-indexed read, a signed DATA_W x DATA_W multiplier and an ACC_W
// wrapping accumulator.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset (accumulator only)
//   i_wr_en/adr/data      coefficient write port
//   i_tap                 coefficient read index for the current sample
//   i_clear               synchronous accumulator clear
//   i_en                  accumulate i_data * coef[i_tap]
//   i_data                signed sample
//   o_acc                 accumulator value
module mac_lane
    import conv_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ACC_W  = DEF_ACC_W,
    parameter int unsigned WIN    = DEF_WIN,
    localparam int unsigned TAP_W = $clog2(WIN)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_en,
    input  logic [TAP_W-1:0]  i_wr_adr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [TAP_W-1:0]  i_tap,
    input  logic              i_clear,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_data,
    output logic [ACC_W-1:0]  o_acc
);

    localparam int unsigned PROD_W = 2 * DATA_W;

    logic signed [DATA_W-1:0] r_coef [WIN];
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  r_acc;

    // Coefficients are intentionally outside reset so they survive rst.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_coef[i_wr_adr] <= i_wr_data;
        end
    end

    // Size casts of signed operands sign-extend, giving a full-precision product.
    always_comb begin
        w_prod     = PROD_W'($signed(i_data)) * PROD_W'(r_coef[i_tap]);
        w_prod_ext = ACC_W'(w_prod);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + w_prod_ext;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/conv_mac_engine.sv
// conv_mac_engine
// Multi-filter convolution engine. NUM_FILTERS lanes multiply-accumulate each
// accepted sample in parallel; after WIN taps the per-filter results drain one
// per handshake, for num_windows windows per run.
// Ports:
//   i_clk, i_rst                   clock, synchronous active-high reset
//   i_flt_wr_en/sel/adr/data       coefficient write (IDLE only)
//   i_start, i_num_windows, i_relu_en   run control (sampled in IDLE)
//   i_in_valid, o_in_ready, i_in_data   sample stream
//   o_out_valid, i_out_ready, o_out_filter, o_out_data   result stream
//   o_busy                         high outside IDLE
//   o_done                         one-cycle pulse at run end
module conv_mac_engine
    import conv_pkg::*;
#(
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned ACC_W       = DEF_ACC_W,
    parameter int unsigned NUM_FILTERS = DEF_NUM_FILTERS,
    parameter int unsigned WIN         = DEF_WIN,
    localparam int unsigned SEL_W      = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1,
    localparam int unsigned TAP_W      = $clog2(WIN)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_flt_wr_en,
    input  logic [SEL_W-1:0]     i_flt_wr_sel,
    input  logic [TAP_W-1:0]     i_flt_wr_adr,
    input  logic [DATA_W-1:0]    i_flt_wr_data,
    input  logic                 i_start,
    input  logic [NUM_WIN_W-1:0] i_num_windows,
    input  logic                 i_relu_en,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [DATA_W-1:0]    i_in_data,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [SEL_W-1:0]     o_out_filter,
    output logic [ACC_W-1:0]     o_out_data,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(WIN - 1);
    localparam logic [SEL_W-1:0] LAST_FLT = SEL_W'(NUM_FILTERS - 1);

    state_t                 r_state;
    logic [TAP_W-1:0]       r_tap_cnt;
    logic [SEL_W-1:0]       r_drain_cnt;
    logic [NUM_WIN_W-1:0]   r_win_cnt;
    logic                   r_relu;

    logic                   w_in_hs;
    logic                   w_out_hs;
    logic                   w_last_drain;
    logic                   w_clear;
    logic [ACC_W-1:0]       w_acc [NUM_FILTERS];
    logic [ACC_W-1:0]       w_sel_acc;

    assign o_busy       = (r_state != IDLE);
    assign o_done       = (r_state == DONE);
    assign o_in_ready   = (r_state == ACCUM);
    assign o_out_valid  = (r_state == DRAIN);
    assign o_out_filter = r_drain_cnt;

    assign w_in_hs      = o_in_ready && i_in_valid;
    assign w_out_hs     = o_out_valid && i_out_ready;
    assign w_last_drain = w_out_hs && (r_drain_cnt == LAST_FLT);
    // Holding clear through IDLE readies the first window; the final drain
    // handshake readies every following one.
    assign w_clear      = (r_state == IDLE) || w_last_drain;

    assign w_sel_acc  = w_acc[r_drain_cnt];
    assign o_out_data = (o_out_valid && !relu_zero(r_relu, w_sel_acc[ACC_W-1])) ? w_sel_acc : '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_tap_cnt   <= '0;
            r_drain_cnt <= '0;
            r_win_cnt   <= '0;
            r_relu      <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_tap_cnt   <= '0;
                        r_drain_cnt <= '0;
                        r_win_cnt   <= i_num_windows;
                        r_relu      <= i_relu_en;
                        r_state     <= (i_num_windows != '0) ? ACCUM : DONE;
                    end
                end
                ACCUM: begin
                    if (w_in_hs) begin
                        if (r_tap_cnt == LAST_TAP) begin
                            r_tap_cnt   <= '0;
                            r_drain_cnt <= '0;
                            r_state     <= DRAIN;
                        end else begin
                            r_tap_cnt <= r_tap_cnt + TAP_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (w_out_hs) begin
                        if (r_drain_cnt == LAST_FLT) begin
                            r_drain_cnt <= '0;
                            r_win_cnt   <= r_win_cnt - NUM_WIN_W'(1);
                            r_state     <= (r_win_cnt == NUM_WIN_W'(1)) ? DONE : ACCUM;
                        end else begin
                            r_drain_cnt <= r_drain_cnt + SEL_W'(1);
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    for (genvar f = 0; f < NUM_FILTERS; f++) begin : g_lane
        logic w_wr_en;
        // Coefficients only change in IDLE so they are stable for a whole run.
        assign w_wr_en = (r_state == IDLE) && i_flt_wr_en && (i_flt_wr_sel == SEL_W'(f));

        mac_lane #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W),
            .WIN    (WIN)
        ) u_mac_lane (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_wr_en   (w_wr_en),
            .i_wr_adr  (i_flt_wr_adr),
            .i_wr_data (i_flt_wr_data),
            .i_tap     (r_tap_cnt),
            .i_clear   (w_clear),
            .i_en      (w_in_hs),
            .i_data    (i_in_data),
            .o_acc     (w_acc[f])
        );
    end

endmodule

// File: tb/tb_conv_mac_engine.sv
// tb_conv_mac_engine
// Drives two engine instances (ACC_W=24 and ACC_W=16) with identical stimulus
// and compares every result against a per-window dot-product model.
module tb_conv_mac_engine;

    localparam int DW  = 8;
    localparam int AW  = 24;
    localparam int AW2 = 16;
    localparam int NF  = 4;
    localparam int WN  = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        flt_wr_en;
    logic [1:0]  flt_wr_sel;
    logic [3:0]  flt_wr_adr;
    logic [7:0]  flt_wr_data;
    logic        start;
    logic [15:0] num_windows;
    logic        relu_en;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        out_ready;

    logic        in_ready, out_valid, busy, done;
    logic [1:0]  out_filter;
    logic [23:0] out_data;
    logic        in_ready2, out_valid2, busy2, done2;
    logic [1:0]  out_filter2;
    logic [15:0] out_data2;

    int coef_m [NF][WN];
    int samp [$];
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    conv_mac_engine #(
        .DATA_W(DW), .ACC_W(AW), .NUM_FILTERS(NF), .WIN(WN)
    ) u_dut (
        .i_clk(clk), .i_rst(rst),
        .i_flt_wr_en(flt_wr_en), .i_flt_wr_sel(flt_wr_sel),
        .i_flt_wr_adr(flt_wr_adr), .i_flt_wr_data(flt_wr_data),
        .i_start(start), .i_num_windows(num_windows), .i_relu_en(relu_en),
        .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
        .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_out_filter(out_filter), .o_out_data(out_data),
        .o_busy(busy), .o_done(done)
    );

    conv_mac_engine #(
        .DATA_W(DW), .ACC_W(AW2), .NUM_FILTERS(NF), .WIN(WN)
    ) u_dut16 (
        .i_clk(clk), .i_rst(rst),
        .i_flt_wr_en(flt_wr_en), .i_flt_wr_sel(flt_wr_sel),
        .i_flt_wr_adr(flt_wr_adr), .i_flt_wr_data(flt_wr_data),
        .i_start(start), .i_num_windows(num_windows), .i_relu_en(relu_en),
        .i_in_valid(in_valid), .o_in_ready(in_ready2), .i_in_data(in_data),
        .o_out_valid(out_valid2), .i_out_ready(out_ready),
        .o_out_filter(out_filter2), .o_out_data(out_data2),
        .o_busy(busy2), .o_done(done2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected result of a window sum s at accumulator width w.
    function automatic logic [31:0] model(input longint s, input int w, input bit relu);
        longint m;
        m = s & ((longint'(1) << w) - 1);
        if (relu && m[w-1]) return 32'd0;
        return 32'(m);
    endfunction

    task automatic wr(input int f, input int t, input int v);
        flt_wr_en   = 1'b1;
        flt_wr_sel  = 2'(f);
        flt_wr_adr  = 4'(t);
        flt_wr_data = 8'(v);
        step();
        flt_wr_en   = 1'b0;
        coef_m[f][t] = v;
    endtask

    function automatic int rnd8();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    // One complete run over samp[]; stall_idx<0 disables the out_ready stall.
    task automatic run(input int nw, input bit relu, input bit rnd_valid,
                       input int stall_idx, input bit inject);
        int exp_f [$];
        logic [31:0] e24 [$];
        logic [31:0] e16 [$];
        int si = 0;
        int got = 0;
        int stall_left = 0;
        int cyc = 0;
        bit armed;
        bit injected = 1'b0;
        bit last_acc = 1'b0;
        bit last_drain = 1'b0;
        bit seen_done = 1'b0;
        longint s;
        armed = (stall_idx >= 0);
        for (int w = 0; w < nw; w++) begin
            for (int f = 0; f < NF; f++) begin
                s = 0;
                for (int t = 0; t < WN; t++) s += longint'(coef_m[f][t]) * longint'(samp[w*WN+t]);
                exp_f.push_back(f);
                e24.push_back(model(s, AW, relu));
                e16.push_back(model(s, AW2, relu));
            end
        end

        num_windows = 16'(nw);
        relu_en     = relu;
        start       = 1'b1;
        step();
        start       = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_in_ready", in_ready, 1);

        while (cyc < 3000) begin
            flt_wr_en = 1'b0;
            start     = 1'b0;
            if (last_acc) chk("last_tap_out_valid", out_valid, 1);
            last_acc = 1'b0;
            if (last_drain) begin
                chk("done_pulse", done, 1);
                chk("done_busy", busy, 1);
                chk("done_no_valid", out_valid, 0);
                seen_done = 1'b1;
                break;
            end
            if (done) chk("early_done", done, 0);

            in_valid = (si < nw * WN) && (!rnd_valid || $urandom_range(0, 3) != 0);
            in_data  = in_valid ? 8'(samp[si]) : 8'($urandom);
            if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else if (armed && out_valid && got == stall_idx) begin
                out_ready  = 1'b0;
                stall_left = 4;
                armed      = 1'b0;
            end else begin
                out_ready = 1'b1;
            end
            if (inject && !injected && in_ready && si == 3) begin
                flt_wr_en   = 1'b1;
                flt_wr_sel  = 2'd0;
                flt_wr_adr  = 4'd0;
                flt_wr_data = 8'(~coef_m[0][0]);
                start       = 1'b1;
                num_windows = 16'd0;
                injected    = 1'b1;
            end

            if (out_valid) begin
                chk("drain_in_ready_low", in_ready, 0);
                if (exp_f.size() == 0) begin
                    chk("unexpected_result", out_valid, 0);
                end else begin
                    chk("out_filter", out_filter, exp_f[0]);
                    chk("out_data24", out_data, e24[0]);
                    chk("out_data16", out_data2, e16[0]);
                    if (out_ready) begin
                        void'(exp_f.pop_front());
                        void'(e24.pop_front());
                        void'(e16.pop_front());
                        got++;
                        if (exp_f.size() == 0) last_drain = 1'b1;
                    end
                end
            end
            if (in_valid && in_ready) begin
                si++;
                if (si % WN == 0) last_acc = 1'b1;
            end
            step();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flt_wr_en = 1'b0;
        start     = 1'b0;
        chk("run_completed", seen_done, 1);
        chk("results_left", exp_f.size(), 0);
        step();
        chk("end_idle_busy", busy, 0);
        chk("end_idle_done", done, 0);
    endtask

    initial begin
        rst = 1'b1; flt_wr_en = 1'b0; flt_wr_sel = '0; flt_wr_adr = '0; flt_wr_data = '0;
        start = 1'b0; num_windows = '0; relu_en = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_out_filter", out_filter, 0);
        chk("rst_out_data", out_data, 0);

        // All-ones coefficients, samples 1..16 -> 136 per filter.
        for (int f = 0; f < NF; f++) for (int t = 0; t < WN; t++) wr(f, t, 1);
        samp.delete();
        for (int t = 0; t < WN; t++) samp.push_back(t + 1);
        run(1, 1'b0, 1'b0, -1, 1'b0);

        // Coefficients f-2, samples 3, ReLU -> 0,0,0,48.
        for (int f = 0; f < NF; f++) for (int t = 0; t < WN; t++) wr(f, t, f - 2);
        samp.delete();
        for (int t = 0; t < WN; t++) samp.push_back(3);
        run(1, 1'b1, 1'b0, -1, 1'b0);

        // Extreme magnitudes: 262144 at 24 bits, wraps to 0 at 16 bits.
        for (int f = 0; f < NF; f++) for (int t = 0; t < WN; t++) wr(f, t, -128);
        samp.delete();
        for (int t = 0; t < WN; t++) samp.push_back(-128);
        run(1, 1'b0, 1'b0, -1, 1'b0);

        // Three windows, random valid gaps, mid-drain stall, ignored start/write.
        for (int f = 0; f < NF; f++) for (int t = 0; t < WN; t++) wr(f, t, rnd8());
        samp.delete();
        for (int i = 0; i < 3 * WN; i++) samp.push_back(rnd8());
        run(3, 1'b0, 1'b1, 5, 1'b1);
        // Same coefficients again: the ignored write must not have landed.
        samp.delete();
        for (int i = 0; i < WN; i++) samp.push_back(rnd8());
        run(1, 1'b0, 1'b0, -1, 1'b0);

        // Zero-window run.
        num_windows = 16'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("nw0_done", done, 1);
        chk("nw0_busy", busy, 1);
        chk("nw0_out_valid", out_valid, 0);
        step();
        chk("nw0_done_end", done, 0);
        chk("nw0_busy_end", busy, 0);
        chk("nw0_out_valid_end", out_valid, 0);

        // Reset in the middle of ACCUM, then a clean run.
        num_windows = 16'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            step();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_done", done, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("midrst_no_done", done, 0);
        end
        samp.delete();
        for (int i = 0; i < WN; i++) samp.push_back(rnd8());
        run(1, 1'b0, 1'b0, -1, 1'b0);

        // Random coefficients, two windows, random ReLU, valid gaps and a stall.
        for (int f = 0; f < NF; f++) for (int t = 0; t < WN; t++) wr(f, t, rnd8());
        samp.delete();
        for (int i = 0; i < 2 * WN; i++) samp.push_back(rnd8());
        run(2, 1'($urandom_range(0, 1)), 1'b1, 2, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
